// File: rtl/fifo_byte_packer.sv
// fifo_byte_packer: read-side drain stage for the asynchronous FIFO.
// Pops bytes through rd_en/empty/d_out (data one clock after the pop) and
// packs them little-endian into 32-bit words on a valid/ready stream with a
// contiguous keep mask. Partial words leave on flush or, when the macro
// PACKER_TIMEOUT_EN is defined, after TIMEOUT_CYCLES idle cycles.
module fifo_byte_packer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        rd_clk,
  input  logic        rd_rst,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_d_out,
  output logic        fifo_rd_en,
  input  logic        flush,
  output logic [31:0] m_data,
  output logic [3:0]  m_keep,
  output logic        m_valid,
  input  logic        m_ready
);

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d, acc_cur;
  logic [2:0]  acc_cnt_q, acc_cnt_d, cnt_cur;
  logic        pend_q;
  logic        slot_free, full_now, flush_req, to_hit;
  logic        load;
  logic [31:0] load_data, part_data;
  logic [3:0]  load_keep, part_keep;

  // Accumulator view including the byte landing this cycle
  always_comb begin
    acc_cur = acc_q;
    if (pend_q) begin
      acc_cur[{acc_cnt_q[1:0], 3'b000} +: 8] = fifo_d_out;
    end
  end

  assign cnt_cur   = acc_cnt_q + {2'b00, pend_q};
  assign slot_free = !m_valid || m_ready;
  assign full_now  = (cnt_cur == 3'd4);

  // A completing word that leaves this cycle frees the accumulator, so the
  // pop for the next word's first byte may overlap it (1 byte/clk).
  assign fifo_rd_en = rd_rst && !fifo_empty && (state_q == ACC) &&
                      ((cnt_cur < 3'd4) || (full_now && slot_free));

  // Partial word: bytes beyond acc_cnt forced to zero, keep contiguous from bit 0
  always_comb begin
    part_data = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if ({29'd0, acc_cnt_q} > i) begin
        part_data[i*8 +: 8] = acc_q[i*8 +: 8];
      end
    end
    case (acc_cnt_q)
      3'd0:    part_keep = 4'b0000;
      3'd1:    part_keep = 4'b0001;
      3'd2:    part_keep = 4'b0011;
      3'd3:    part_keep = 4'b0111;
      default: part_keep = 4'b1111;
    endcase
  end

`ifdef PACKER_TIMEOUT_EN
  logic [15:0] to_cnt_q;

  assign to_hit = (to_cnt_q == 16'(TIMEOUT_CYCLES));

  // Idle counter: runs in ACC with a partial word and no capture
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      to_cnt_q <= '0;
    end else if (to_hit || pend_q || (state_q != ACC) || (acc_cnt_q == 3'd0)) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 16'd1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  assign flush_req = flush || to_hit;

  // Next-state and accumulator/output-load decisions
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_cur;
    acc_cnt_d = cnt_cur;
    load      = 1'b0;
    load_data = acc_cur;
    load_keep = 4'b1111;
    case (state_q)
      ACC: begin
        if (full_now) begin
          if (slot_free) begin
            load      = 1'b1;
            acc_d     = '0;
            acc_cnt_d = 3'd0;
          end else begin
            state_d = HOLD;
          end
        end else if (flush_req && (cnt_cur != 3'd0)) begin
          // Nothing in flight and a free slot: emit now instead of passing
          // through FLUSH, giving one-cycle flush latency.
          if (!pend_q && slot_free) begin
            load      = 1'b1;
            load_data = part_data;
            load_keep = part_keep;
            acc_d     = '0;
            acc_cnt_d = 3'd0;
          end else begin
            state_d = FLUSH;
          end
        end
      end
      HOLD: begin
        if (slot_free) begin
          load      = 1'b1;
          acc_d     = '0;
          acc_cnt_d = 3'd0;
          state_d   = ACC;
        end
      end
      FLUSH: begin
        if (!pend_q && slot_free) begin
          load      = 1'b1;
          load_data = part_data;
          load_keep = part_keep;
          acc_d     = '0;
          acc_cnt_d = 3'd0;
          state_d   = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // State, accumulator and in-flight flag
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      state_q   <= ACC;
      acc_q     <= '0;
      acc_cnt_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      pend_q    <= fifo_rd_en;
    end
  end

  // Output register: loads a word or retires it on handshake
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
      m_keep  <= load_keep;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Testbench for fifo_byte_packer: FIFO model feeding the packer, a byte-level
// reference model producing expected words into a scoreboard queue, and a
// monitor comparing every accepted word.
module tb_fifo_byte_packer;

  logic        rd_clk     = 1'b0;
  logic        rd_rst     = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_d_out = 8'h00;
  logic        fifo_rd_en;
  logic        flush      = 1'b0;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;
  logic        m_ready    = 1'b0;

  always #5 rd_clk = ~rd_clk;

  fifo_byte_packer #(.TIMEOUT_CYCLES(8)) dut (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .fifo_empty (fifo_empty),
    .fifo_d_out (fifo_d_out),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_valid    (m_valid),
    .m_ready    (m_ready)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
  } word_t;

  word_t       exp_q[$];
  logic [7:0]  fifo_q[$];
  logic [7:0]  model_b[$];
  int          n_checks = 0;
  int          n_bad = 0;
  int          pops_total = 0;
  logic        pop_s = 1'b0;
  logic        held_v = 1'b0;
  logic [31:0] held_d = '0;
  logic [3:0]  held_k = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_bad++;
    $display("FAIL %s: actual=timeout required=completion", name);
  endtask

  // Reference: bytes in arrival order; each group of four is a full word,
  // a flush closes whatever remainder is left as a partial word.
  task automatic model_close(input bit partial);
    word_t w;
    int    n;
    while (model_b.size() >= 4 || (partial && model_b.size() > 0)) begin
      n = (model_b.size() >= 4) ? 4 : model_b.size();
      w.data = '0;
      for (int i = 0; i < n; i++) w.data += 32'(model_b.pop_front()) << (8 * i);
      w.keep = 4'((1 << n) - 1);
      exp_q.push_back(w);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    model_b.push_back(b);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) push_byte(8'($urandom));
  endtask

  task automatic wait_drain(input int budget, input bit rnd);
    int k = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && k < budget) begin
      @(negedge rd_clk);
      m_ready = rnd ? 1'($urandom) : 1'b1;
      k++;
    end
    if (k >= budget) fail_now("drain");
    @(negedge rd_clk);
    m_ready = 1'b1;
    repeat (2) @(negedge rd_clk);
  endtask

  // FIFO read side: data appears one clock after a pop, garbage otherwise
  initial forever begin
    @(negedge rd_clk);
    #2 fifo_empty = (fifo_q.size() == 0);
    #1 pop_s = fifo_rd_en;
    if (pop_s) chk("pop_when_empty", 64'(fifo_empty), 64'd0);
    @(posedge rd_clk);
    #1;
    if (pop_s && fifo_q.size() > 0) begin
      fifo_d_out = fifo_q.pop_front();
      pops_total++;
    end else begin
      fifo_d_out = 8'($urandom);
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  // Monitor: compare accepted words, check held words stay stable
  initial forever begin
    @(negedge rd_clk);
    #4;
    if (!rd_rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("hold_valid", 64'(m_valid), 64'd1);
        chk("hold_data", 64'(m_data), 64'(held_d));
        chk("hold_keep", 64'(m_keep), 64'(held_k));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_bad++;
          $display("FAIL unexpected_word: actual=0x%h keep=%b required=no word", m_data, m_keep);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          chk("word_data", 64'(m_data), 64'(e.data));
          chk("word_keep", 64'(m_keep), 64'(e.keep));
        end
      end
      held_v = m_valid && !m_ready;
      held_d = m_data;
      held_k = m_keep;
    end
  end

  initial begin
    int   s, f4, fv, p, cnt, run, seen, base, j, n, k;
    logic en_hist[16];
    logic v_hist[16];

    // Reset with bytes already waiting in the FIFO
    for (int i = 1; i <= 8; i++) push_byte(8'(i * 17));
    model_close(0);
    repeat (3) @(negedge rd_clk);
    #3;
    chk("reset_m_valid", 64'(m_valid), 64'd0);
    chk("reset_m_data", 64'(m_data), 64'd0);
    chk("reset_m_keep", 64'(m_keep), 64'd0);
    chk("reset_rd_en", 64'(fifo_rd_en), 64'd0);

    // Streaming at one byte per clock
    @(negedge rd_clk);
    rd_rst  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #3;
      en_hist[i] = fifo_rd_en;
      v_hist[i]  = m_valid;
      @(negedge rd_clk);
    end
    s = -1; f4 = -1; fv = -1; cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (en_hist[i]) begin
        cnt++;
        if (s < 0) s = i;
        if (cnt == 4) f4 = i;
      end
      if (v_hist[i] && fv < 0) fv = i;
    end
    run = 0;
    if (s >= 0) begin
      j = s;
      while (j < 16 && en_hist[j]) j++;
      run = j - s;
    end
    chk("rd_en_run", 64'(run), 64'd8);
    chk("pop4_to_valid", 64'(fv - f4), 64'd2);
    wait_drain(100, 0);

    // Flush while the third byte is in flight
    push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      #3;
      if (fifo_rd_en && fifo_q.size() == 1) seen = 1;
      @(negedge rd_clk);
    end
    if (seen == 0) fail_now("last_pop");
    flush = 1'b1;
    model_close(1);
    #3;
    @(negedge rd_clk);
    flush = 1'b0;
    fv = -1;
    for (int i = 1; i <= 6; i++) begin
      #3;
      if (m_valid && fv < 0) fv = i;
      @(negedge rd_clk);
    end
    chk("flush_inflight_latency", 64'(fv), 64'd2);
    wait_drain(50, 0);
    #3;
    chk("valid_low_after_flush", 64'(m_valid), 64'd0);

    // Flush with nothing in flight
    @(negedge rd_clk);
    push_byte(8'hD4);
    repeat (4) @(negedge rd_clk);
    flush = 1'b1;
    model_close(1);
    #3;
    @(negedge rd_clk);
    flush = 1'b0;
    fv = -1;
    for (int i = 1; i <= 6; i++) begin
      #3;
      if (m_valid && fv < 0) fv = i;
      @(negedge rd_clk);
    end
    chk("flush_idle_latency", 64'(fv), 64'd1);
    wait_drain(50, 0);

    // Back-pressure: 12 bytes queued, sink stalled
    m_ready = 1'b0;
    base = pops_total;
    push_rand(12);
    model_close(0);
    repeat (30) @(negedge rd_clk);
    #3;
    chk("bp_pop_count", 64'(pops_total - base), 64'd8);
    chk("bp_rd_en_low", 64'(fifo_rd_en), 64'd0);
    chk("bp_valid_held", 64'(m_valid), 64'd1);
    wait_drain(100, 0);

    // Flush with an empty accumulator is ignored
    flush = 1'b1;
    @(negedge rd_clk);
    flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      #3;
      if (m_valid) seen = 1;
      @(negedge rd_clk);
    end
    chk("empty_flush_no_valid", 64'(seen), 64'd0);

    // Flush while holding a full word is ignored
    m_ready = 1'b0;
    push_rand(8);
    model_close(0);
    repeat (15) @(negedge rd_clk);
    flush = 1'b1;
    @(negedge rd_clk);
    flush = 1'b0;
    repeat (3) @(negedge rd_clk);
    wait_drain(100, 0);
    repeat (8) @(negedge rd_clk);
    #3;
    chk("hold_flush_no_extra", 64'(m_valid), 64'd0);

    // Reset mid-word: bytes not modelled, they must vanish
    @(negedge rd_clk);
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'($urandom));
    repeat (12) @(negedge rd_clk);
    #3;
    chk("pre_reset_valid", 64'(m_valid), 64'd1);
    @(negedge rd_clk);
    rd_rst = 1'b0;
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_keep", 64'(m_keep), 64'd0);
    repeat (2) @(negedge rd_clk);
    rd_rst  = 1'b1;
    m_ready = 1'b1;
    push_rand(4);
    model_close(0);
    wait_drain(50, 0);

    // Single byte followed by an idle FIFO
    push_byte(8'h5A);
`ifdef PACKER_TIMEOUT_EN
    model_close(1);
    p = -1; fv = -1;
    for (int i = 0; i < 30; i++) begin
      #3;
      if (fifo_rd_en && p < 0) p = i;
      if (m_valid && fv < 0) fv = i;
      @(negedge rd_clk);
    end
    chk("timeout_window", 64'((p >= 0) && (fv - p >= 10) && (fv - p <= 12)), 64'd1);
    wait_drain(50, 0);
`else
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      #3;
      if (m_valid) seen = 1;
      @(negedge rd_clk);
    end
    chk("no_timeout_word", 64'(seen), 64'd0);
    flush = 1'b1;
    model_close(1);
    @(negedge rd_clk);
    flush = 1'b0;
    wait_drain(50, 0);
`endif

    // Randomized traffic with random sink stalls and trailing flushes
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(1, 3);
      k = $urandom_range(0, 3);
      push_rand(4 * n + k);
      model_close(0);
      j = 0;
      while (fifo_q.size() != 0 && j < 200) begin
        @(negedge rd_clk);
        m_ready = 1'($urandom);
        j++;
      end
      if (j >= 200) fail_now("fifo_empty_wait");
      repeat (3) begin
        @(negedge rd_clk);
        m_ready = 1'($urandom);
      end
      if (k > 0) begin
        @(negedge rd_clk);
        flush = 1'b1;
        model_close(1);
        @(negedge rd_clk);
        flush = 1'b0;
      end
      wait_drain(200, 1);
    end

    wait_drain(200, 0);
    repeat (4) @(negedge rd_clk);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
